memsync_arbiter: RTL and testbench

- Shares one MEMSync row-cache tag controller between NREQ requesters with round-robin arbitration.
- Sequences the MEMSync stall/sync handshake. Whenever MEMSync stalls (WriteBack or Allocate), it starts an external row-transfer engine, waits for completion, then pulses sync.
- Sits between the requesters (e.g. PIM units) and MEMSync. The transfer engine is outside this block.

---
 rtl/memsync_pkg.sv | 27 ++
 rtl/memsync_arbiter_rr.sv | 24 ++
 rtl/memsync_arbiter.sv | 160 ++++++++++++++++
 tb/tb_memsync_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memsync_pkg.sv
// Shared types for the MEMSync arbiter: FSM states, access op and the
// latched request record.
package memsync_pkg;

    // Row id width of the MEMSync tag controller this block is built against.
    localparam int MS_ADDRWIDTH = 17;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        XFER,
        SYNC,
        SETTLE,
        GAP
    } arb_state_t;

    typedef enum logic {
        OP_RD,
        OP_WR
    } mem_op_t;

    typedef struct packed {
        mem_op_t                 op;
        logic [MS_ADDRWIDTH-1:0] rowid;
    } mem_req_t;

endpackage

// File: rtl/memsync_arbiter_rr.sv
// Round-robin pick: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int  NREQ = 4,
    localparam int PTRW = $clog2(NREQ)
)(
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [PTRW-1:0] gnt,
    output logic            valid
);

    // Scan NREQ slots starting at ptr; the first hit wins.
    always_comb begin
        gnt   = '0;
        valid = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[(int'(ptr) + i) % NREQ]) begin
                valid = 1'b1;
                gnt   = PTRW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/memsync_arbiter.sv
// Shares one MEMSync tag controller between NREQ requesters and runs the
// stall -> row transfer -> sync handshake for each stall episode.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | no transaction; arbitrate from the RR pointer
//  ISSUE  | command on MEMSync, counting non-stall cycles
//  XFER   | stalled; transfer engine running, timeout down-counter live
//  SYNC   | one-cycle sync pulse to MEMSync
//  SETTLE | one cycle with stall ignored before re-issuing
//  GAP    | command dropped, ack pulsed; also arbitrates the next grant
module memsync_arbiter
    import memsync_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int CHWIDTH      = 6,
    parameter int ADDRWIDTH    = MS_ADDRWIDTH,
    parameter int HIT_WAIT     = 2,
    parameter int XFER_TIMEOUT = 1024
)(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_rd,
    input  logic [NREQ-1:0]           req_wr,
    input  logic [NREQ*ADDRWIDTH-1:0] req_rowid,
    output logic [NREQ-1:0]           req_ack,
    output logic [CHWIDTH-1:0]        req_crowid,
    output logic                      ms_rd,
    output logic                      ms_wr,
    output logic [ADDRWIDTH-1:0]      ms_rowid,
    output logic                      ms_sync,
    input  logic                      ms_stall,
    input  logic [CHWIDTH-1:0]        ms_crowid,
    output logic                      xfer_start,
    input  logic                      xfer_done,
    output logic                      busy,
    output logic                      err_timeout,
    output logic                      err_proto
);

    localparam int PTRW = $clog2(NREQ);
    localparam int HCW  = $clog2(HIT_WAIT + 1);
    localparam int XCW  = $clog2(XFER_TIMEOUT + 1);

    // The latched request record is sized by the package.
    if (ADDRWIDTH != MS_ADDRWIDTH) begin : g_width_check
        $error("memsync_arbiter: ADDRWIDTH must equal memsync_pkg::MS_ADDRWIDTH");
    end

    arb_state_t      state_q, state_d;
    logic [PTRW-1:0] ptr_q, gidx_q, next_ptr, arb_ptr, arb_gnt;
    logic [NREQ-1:0] gnt_mask, arb_req;
    logic            arb_valid;
    mem_req_t        cur_q;
    logic [HCW-1:0]  hit_q;
    logic [XCW-1:0]  xcnt_q;
    logic            hit_done, xfer_tc, cmd_active, grant_slot;

    assign next_ptr   = (gidx_q == PTRW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
    assign gnt_mask   = NREQ'(1) << gidx_q;
    assign grant_slot = (state_q == IDLE) || (state_q == GAP);
    // In GAP the acked requester still holds its line, so it is masked out
    // and the scan starts past it; other requesters get a one-bubble re-grant.
    assign arb_ptr    = (state_q == GAP) ? next_ptr : ptr_q;
    assign arb_req    = (state_q == GAP) ? ((req_rd | req_wr) & ~gnt_mask)
                                         : (req_rd | req_wr);
    assign hit_done   = (hit_q == HCW'(HIT_WAIT - 1));
    assign xfer_tc    = (xcnt_q == XCW'(1));

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req   (arb_req),
        .ptr   (arb_ptr),
        .gnt   (arb_gnt),
        .valid (arb_valid)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = ISSUE;
            ISSUE:   if (ms_stall) state_d = XFER;
                     else if (hit_done) state_d = GAP;
            XFER:    if (xfer_done || xfer_tc) state_d = SYNC;
            SYNC:    state_d = SETTLE;
            SETTLE:  state_d = ISSUE;
            GAP:     state_d = arb_valid ? ISSUE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the registered state and latched request.
    assign cmd_active = (state_q == ISSUE) || (state_q == XFER) ||
                        (state_q == SYNC)  || (state_q == SETTLE);
    assign ms_wr      = cmd_active && (cur_q.op == OP_WR);
    assign ms_rd      = cmd_active && (cur_q.op == OP_RD);
    assign ms_rowid   = cmd_active ? cur_q.rowid : '0;
    assign ms_sync    = (state_q == SYNC);
    assign busy       = (state_q != IDLE);

    // One-hot ack for the request being retired.
    always_comb begin
        req_ack = '0;
        if (state_q == GAP) req_ack = gnt_mask;
    end

    // Grant latch, RR pointer and protocol error flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q     <= '0;
            gidx_q    <= '0;
            cur_q     <= '0;
            err_proto <= 1'b0;
        end else begin
            if (state_q == GAP) ptr_q <= next_ptr;
            if (grant_slot && arb_valid) begin
                gidx_q      <= arb_gnt;
                cur_q.op    <= req_wr[arb_gnt] ? OP_WR : OP_RD;
                cur_q.rowid <= req_rowid[int'(arb_gnt)*ADDRWIDTH +: ADDRWIDTH];
                if (req_wr[arb_gnt] && req_rd[arb_gnt]) err_proto <= 1'b1;
            end
        end
    end

    // Hit counter, transfer timeout down-counter, start pulse and crowid capture.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hit_q       <= '0;
            xcnt_q      <= '0;
            xfer_start  <= 1'b0;
            err_timeout <= 1'b0;
            req_crowid  <= '0;
        end else begin
            xfer_start <= (state_q == ISSUE) && ms_stall;
            case (state_q)
                ISSUE: begin
                    if (ms_stall) begin
                        hit_q  <= '0;
                        xcnt_q <= XCW'(XFER_TIMEOUT);
                    end else begin
                        hit_q <= hit_q + 1'b1;
                        if (hit_done) req_crowid <= ms_crowid;
                    end
                end
                XFER: begin
                    xcnt_q <= xcnt_q - 1'b1;
                    if (!xfer_done && xfer_tc) err_timeout <= 1'b1;
                end
                default: hit_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_memsync_arbiter.sv
// Directed bench for memsync_arbiter (NREQ=4, HIT_WAIT=2, XFER_TIMEOUT=8).
module tb_memsync_arbiter;

    localparam int NREQ = 4;
    localparam int CHW  = 6;
    localparam int AW   = 17;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_rd, req_wr, req_ack;
    logic [NREQ*AW-1:0] req_rowid;
    logic [CHW-1:0]    req_crowid, ms_crowid;
    logic              ms_rd, ms_wr, ms_sync, ms_stall;
    logic [AW-1:0]     ms_rowid;
    logic              xfer_start, xfer_done, busy, err_timeout, err_proto;

    int checks = 0;
    int failures = 0;

    logic [31:0] xs_mask, sync_mask, ack_cmask;
    logic [3:0]  last_ack;
    logic [3:0]  ack_seq [0:7];
    int          n_ack, rd_cnt, wr_cnt;

    memsync_arbiter #(
        .NREQ(NREQ), .CHWIDTH(CHW), .ADDRWIDTH(AW), .HIT_WAIT(2), .XFER_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .req_rd(req_rd), .req_wr(req_wr), .req_rowid(req_rowid),
        .req_ack(req_ack), .req_crowid(req_crowid),
        .ms_rd(ms_rd), .ms_wr(ms_wr), .ms_rowid(ms_rowid), .ms_sync(ms_sync),
        .ms_stall(ms_stall), .ms_crowid(ms_crowid),
        .xfer_start(xfer_start), .xfer_done(xfer_done),
        .busy(busy), .err_timeout(err_timeout), .err_proto(err_proto)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rowid(input int k, input logic [AW-1:0] v);
        req_rowid[k*AW +: AW] = v;
    endtask

    function automatic logic [33:0] all_outs();
        return {req_ack, req_crowid, ms_rd, ms_wr, ms_rowid, ms_sync,
                xfer_start, busy, err_timeout, err_proto};
    endfunction

    task automatic clear_obs();
        xs_mask = '0; sync_mask = '0; ack_cmask = '0; last_ack = '0;
        n_ack = 0; rd_cnt = 0; wr_cnt = 0;
    endtask

    task automatic sample(input int cyc);
        if (xfer_start) xs_mask[cyc] = 1'b1;
        if (ms_sync) sync_mask[cyc] = 1'b1;
        if (|req_ack) begin
            ack_cmask[cyc] = 1'b1;
            last_ack = req_ack;
            if (n_ack < 8) ack_seq[n_ack] = req_ack;
            n_ack++;
        end
        if (ms_rd) rd_cnt++;
        if (ms_wr) wr_cnt++;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_rd = '0; req_wr = '0; req_rowid = '0;
        ms_stall = 1'b0; ms_crowid = '0; xfer_done = 1'b0;
        tick(); tick();
        checks++;
        if (all_outs() !== 34'd0) begin
            failures++; $display("FAIL reset_outputs: got %h expected 0", all_outs());
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy: got %b expected 0", busy);
        end
    endtask

    task automatic test_single_hit();
        ms_crowid = 6'h2B;
        set_rowid(0, 17'h000A5);
        req_wr[0] = 1'b1;
        tick();
        checks++;
        if ({ms_wr, ms_rd, ms_rowid} !== {1'b1, 1'b0, 17'h000A5}) begin
            failures++; $display("FAIL hit_issue: got wr=%b rd=%b row=%h expected wr=1 rd=0 row=000a5",
                                 ms_wr, ms_rd, ms_rowid);
        end
        tick();
        checks++;
        if ({ms_wr, req_ack} !== 5'b1_0000) begin
            failures++; $display("FAIL hit_hold: got wr=%b ack=%b expected wr=1 ack=0000", ms_wr, req_ack);
        end
        tick();
        checks++;
        if ({req_ack, ms_wr, ms_rowid} !== {4'b0001, 1'b0, 17'h0}) begin
            failures++; $display("FAIL hit_ack: got ack=%b wr=%b row=%h expected ack=0001 wr=0 row=0",
                                 req_ack, ms_wr, ms_rowid);
        end
        checks++;
        if (req_crowid !== 6'h2B) begin
            failures++; $display("FAIL hit_crowid: got %h expected 2b", req_crowid);
        end
        req_wr[0] = 1'b0;
        tick();
        checks++;
        if ({busy, req_ack} !== 5'b0) begin
            failures++; $display("FAIL hit_return_idle: got busy=%b ack=%b expected 0", busy, req_ack);
        end
    endtask

    task automatic test_alloc_miss();
        clear_obs();
        ms_crowid = 6'h15;
        set_rowid(1, 17'h01234);
        req_rd[1] = 1'b1;
        ms_stall  = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            sample(c);
            if (c == 1) begin
                checks++;
                if ({ms_rd, ms_rowid} !== {1'b1, 17'h01234}) begin
                    failures++; $display("FAIL miss_issue: got rd=%b row=%h expected rd=1 row=01234",
                                         ms_rd, ms_rowid);
                end
            end
            if (c == 3) ms_stall = 1'b0;
            if (c == 4) xfer_done = 1'b1;
            if (c == 5) xfer_done = 1'b0;
            if (req_ack[1]) req_rd[1] = 1'b0;
        end
        checks++;
        if (xs_mask !== 32'h0000_0004) begin
            failures++; $display("FAIL miss_xfer_start: got %h expected 00000004", xs_mask);
        end
        checks++;
        if (sync_mask !== 32'h0000_0020) begin
            failures++; $display("FAIL miss_sync: got %h expected 00000020", sync_mask);
        end
        checks++;
        if ({ack_cmask, last_ack} !== {32'h0000_0200, 4'b0010}) begin
            failures++; $display("FAIL miss_ack: got cyc=%h ack=%b expected cyc=00000200 ack=0010",
                                 ack_cmask, last_ack);
        end
        checks++;
        if (rd_cnt != 8 || wr_cnt != 0 || req_crowid !== 6'h15) begin
            failures++; $display("FAIL miss_cmd: got rd=%0d wr=%0d crow=%h expected rd=8 wr=0 crow=15",
                                 rd_cnt, wr_cnt, req_crowid);
        end
    endtask

    task automatic test_wb_alloc();
        clear_obs();
        ms_crowid = 6'h3C;
        set_rowid(2, 17'h0BEEF);
        req_rd[2] = 1'b1;
        ms_stall  = 1'b1;
        for (int c = 1; c <= 17; c++) begin
            tick();
            sample(c);
            if (c == 2) ms_stall = 1'b0;
            if (c == 3) xfer_done = 1'b1;
            if (c == 4) begin xfer_done = 1'b0; ms_stall = 1'b1; end
            if (c == 7) ms_stall = 1'b0;
            if (c == 9) xfer_done = 1'b1;
            if (c == 10) xfer_done = 1'b0;
            if (req_ack[2]) req_rd[2] = 1'b0;
        end
        checks++;
        if (xs_mask !== 32'h0000_0084) begin
            failures++; $display("FAIL wb_xfer_start: got %h expected 00000084", xs_mask);
        end
        checks++;
        if (sync_mask !== 32'h0000_0410) begin
            failures++; $display("FAIL wb_sync: got %h expected 00000410", sync_mask);
        end
        checks++;
        if ({ack_cmask, last_ack} !== {32'h0000_4000, 4'b0100} || n_ack != 1) begin
            failures++; $display("FAIL wb_ack: got cyc=%h ack=%b n=%0d expected cyc=00004000 ack=0100 n=1",
                                 ack_cmask, last_ack, n_ack);
        end
        checks++;
        if (rd_cnt != 13 || wr_cnt != 0 || req_crowid !== 6'h3C) begin
            failures++; $display("FAIL wb_cmd: got rd=%0d wr=%0d crow=%h expected rd=13 wr=0 crow=3c",
                                 rd_cnt, wr_cnt, req_crowid);
        end
    endtask

    task automatic test_timeout();
        int et_first;
        int et_cnt;
        et_first = 0;
        et_cnt   = 0;
        clear_obs();
        set_rowid(3, 17'h1FFFF);
        req_rd[3] = 1'b1;
        req_wr[3] = 1'b1;
        ms_stall  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            tick();
            sample(c);
            if (c == 1) begin
                checks++;
                if ({ms_wr, ms_rd, err_proto, ms_rowid} !== {3'b101, 17'h1FFFF}) begin
                    failures++; $display("FAIL proto_write_pri: got wr=%b rd=%b ep=%b row=%h expected 1 0 1 1ffff",
                                         ms_wr, ms_rd, err_proto, ms_rowid);
                end
            end
            if (err_timeout) begin
                if (et_first == 0) et_first = c;
                et_cnt++;
            end
        end
        checks++;
        if (et_first != 10 || et_cnt != 7) begin
            failures++; $display("FAIL timeout_err: got first=%0d cycles=%0d expected first=10 cycles=7",
                                 et_first, et_cnt);
        end
        checks++;
        if (sync_mask !== 32'h0000_0400) begin
            failures++; $display("FAIL timeout_sync: got %h expected 00000400", sync_mask);
        end
        checks++;
        if (xs_mask !== 32'h0000_2004 || n_ack != 0) begin
            failures++; $display("FAIL timeout_restall: got xs=%h acks=%0d expected xs=00002004 acks=0",
                                 xs_mask, n_ack);
        end
    endtask

    task automatic test_reset_mid_xfer();
        clear_obs();
        rst       = 1'b0;
        ms_stall  = 1'b0;
        req_rd    = '0;
        req_wr    = 4'b1001;
        set_rowid(0, 17'h00042);
        tick();
        checks++;
        if (all_outs() !== 34'd0) begin
            failures++; $display("FAIL midreset_outputs: got %h expected 0", all_outs());
        end
        rst       = 1'b1;
        xfer_done = 1'b1;
        for (int c = 2; c <= 9; c++) begin
            tick();
            sample(c);
            xfer_done = 1'b0;
            if (c == 2) begin
                checks++;
                if ({ms_wr, ms_rowid} !== {1'b1, 17'h00042}) begin
                    failures++; $display("FAIL midreset_grant0: got wr=%b row=%h expected wr=1 row=00042",
                                         ms_wr, ms_rowid);
                end
            end
            req_wr = req_wr & ~req_ack;
        end
        checks++;
        if (ack_cmask !== 32'h0000_0090 || ack_seq[0] !== 4'b0001 || ack_seq[1] !== 4'b1000) begin
            failures++; $display("FAIL midreset_acks: got cyc=%h first=%b second=%b expected cyc=00000090 0001 1000",
                                 ack_cmask, ack_seq[0], ack_seq[1]);
        end
        checks++;
        if ({sync_mask, xs_mask, err_timeout, err_proto} !== 66'd0) begin
            failures++; $display("FAIL midreset_quiet: got sync=%h xs=%h et=%b ep=%b expected all 0",
                                 sync_mask, xs_mask, err_timeout, err_proto);
        end
    endtask

    task automatic test_round_robin();
        int wr_lo;
        wr_lo = 0;
        req_wr = '0;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        for (int k = 0; k < NREQ; k++) set_rowid(k, AW'(17'h00100 + k));
        req_wr = 4'b1111;
        clear_obs();
        for (int c = 1; c <= 15; c++) begin
            tick();
            sample(c);
            if (c <= 14 && !ms_wr) wr_lo++;
        end
        req_wr = '0;
        checks++;
        if (n_ack != 5 || {ack_seq[0], ack_seq[1], ack_seq[2], ack_seq[3], ack_seq[4]} !== 20'h12481) begin
            failures++; $display("FAIL rr_order: got n=%0d seq=%h%h%h%h%h expected n=5 seq=12481", n_ack,
                                 ack_seq[0], ack_seq[1], ack_seq[2], ack_seq[3], ack_seq[4]);
        end
        checks++;
        if (ack_cmask !== 32'h0000_9248) begin
            failures++; $display("FAIL rr_ack_cycles: got %h expected 00009248", ack_cmask);
        end
        checks++;
        if (wr_lo != 4) begin
            failures++; $display("FAIL rr_gap_bubble: got %0d low cycles expected 4", wr_lo);
        end
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_single_hit();
        test_alloc_miss();
        test_wb_alloc();
        test_timeout();
        test_reset_mid_xfer();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
